// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a built-in baud divider.
// Frame: start, DATA_WIDTH bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              P_data,
  input  logic                               Data_valid,
  output logic                               Data_ready,
  input  logic                               Par_en,
  input  logic                               Par_type,
  input  logic                               Stop2,
  input  logic [DIV_WIDTH-1:0]               Baud_div,
  output logic                               TX_out,
  output logic                               Busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    Fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]        FULL     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr, pop;

  state_t                state, state_d;
  logic [DIV_WIDTH-1:0]  cnt, cnt_d, n_q;
  logic [BW-1:0]         idx, idx_d;
  logic                  second, second_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic                  par_q, par_en_q, stop2_q;
  logic                  tx_d, busy_d, bit_done;

  assign Data_ready = (count != FULL);
  assign Fifo_count = count;
  assign wr         = Data_valid && Data_ready;
  assign bit_done   = (cnt == n_q - ONE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    second_d = second;
    shift_d  = shift;
    pop      = 1'b0;
    tx_d     = 1'b1;
    busy_d   = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      DATA: begin
        tx_d = shift[0];
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift >> 1;
          if (idx == LAST_BIT) begin
            second_d = 1'b0;
            state_d  = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      PARITY: begin
        tx_d = par_q;
        if (bit_done) begin
          cnt_d    = '0;
          second_d = 1'b0;
          state_d  = STOP;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (stop2_q && !second) begin
            second_d = 1'b1;
          end else if (count != '0) begin
            // Chain straight into the next frame with no idle bit between them.
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      second   <= 1'b0;
      shift    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      n_q      <= ONE;
      TX_out   <= 1'b1;
      Busy     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      second <= second_d;
      TX_out <= tx_d;
      Busy   <= busy_d;
      if (pop) begin
        shift    <= mem[rd_ptr];
        par_q    <= (^mem[rd_ptr]) ^ Par_type;
        par_en_q <= Par_en;
        stop2_q  <= Stop2;
        n_q      <= (Baud_div == '0) ? ONE : Baud_div;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        shift <= shift_d;
      end
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= P_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a line
// monitor decodes TX_out clock by clock and compares against a frame model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DW   = 8;
  localparam int DEPTH = 4;
  localparam int DIVW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            n;
    bit            par_en;
    bit            par_type;
    bit            stop2;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [DW-1:0]   P_data = '0;
  logic            Data_valid = 1'b0;
  logic            Data_ready;
  logic            Par_en = 1'b0;
  logic            Par_type = 1'b0;
  logic            Stop2 = 1'b0;
  logic [DIVW-1:0] Baud_div = 16'd1;
  logic            TX_out;
  logic            Busy;
  logic [$clog2(DEPTH+1)-1:0] Fifo_count;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst(rst), .P_data(P_data), .Data_valid(Data_valid),
    .Data_ready(Data_ready), .Par_en(Par_en), .Par_type(Par_type),
    .Stop2(Stop2), .Baud_div(Baud_div), .TX_out(TX_out), .Busy(Busy),
    .Fifo_count(Fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t make_frame(input logic [DW-1:0] d, input int div,
                                        input bit pe, input bit pt, input bit s2);
    frame_t f;
    f.data = d; f.n = (div == 0) ? 1 : div;
    f.par_en = pe; f.par_type = pt; f.stop2 = s2;
    return f;
  endfunction

  function automatic int frame_bits(input frame_t f);
    return 1 + DW + int'(f.par_en) + 1 + int'(f.stop2);
  endfunction

  // Line level of serial bit k of a frame, from the framing rules.
  function automatic logic bit_at(input frame_t f, input int k);
    int ones = 0;
    if (k == 0) return 1'b0;
    if (k <= DW) return f.data[k-1];
    if (f.par_en && k == DW + 1) begin
      for (int i = 0; i < DW; i++) ones += int'(f.data[i]);
      return logic'((ones % 2) == 1) ^ f.par_type;
    end
    return 1'b1;
  endfunction

  initial begin : monitor
    frame_t f;
    int     bad;
    bit     aborted;
    forever begin
      @(negedge clk);
      if (rst && TX_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          bad = 0;
          aborted = 1'b0;
          for (int i = 0; i < frame_bits(f) * f.n; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst) begin
              aborted = 1'b1;
              break;
            end
            if (TX_out !== bit_at(f, i / f.n)) bad++;
          end
          if (!aborted) check($sformatf("frame_%02h_bad_clocks", f.data), bad, 0);
        end
      end
    end
  end

  task automatic send(input frame_t f);
    int w = 0;
    @(negedge clk);
    P_data = f.data;
    Data_valid = 1'b1;
    while (!Data_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!Data_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(f);
      @(posedge clk);
    end
    #1 Data_valid = 1'b0;
  endtask

  task automatic measure_busy(output int len);
    int w = 0;
    len = 0;
    @(negedge clk);
    while (!Busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    while (Busy && len < 3000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    int quiet = 0;
    while (quiet < 4 && w < 20000) begin
      @(negedge clk);
      w++;
      if (exp_q.size() == 0 && !Busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check("idle_timeout", w, 0);
  endtask

  task automatic single(input frame_t f, input int div, input int exp_len, input string nm);
    int len;
    @(negedge clk);
    Baud_div = DIVW'(div); Par_en = f.par_en; Par_type = f.par_type; Stop2 = f.stop2;
    fork
      send(f);
      measure_busy(len);
    join
    check(nm, len, exp_len);
    wait_idle();
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int len, bad, w, div;
    bit pe, pt, s2;

    // Reset state, and writes attempted during reset are ignored.
    P_data = 8'h77;
    Data_valid = 1'b1;
    #23;
    check("reset_tx", TX_out, 1);
    check("reset_busy", Busy, 0);
    check("reset_count", Fifo_count, 0);
    check("reset_ready", Data_ready, 1);
    @(negedge clk);
    Data_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_write_ignored", Fifo_count, 0);

    // Basic frame, latency and frame length.
    Baud_div = 16'd4; Par_en = 1'b0; Par_type = 1'b0; Stop2 = 1'b0;
    fork
      begin
        @(negedge clk);
        P_data = 8'hA5;
        Data_valid = 1'b1;
        check("ready_idle", Data_ready, 1);
        exp_q.push_back(make_frame(8'hA5, 4, 0, 0, 0));
        @(posedge clk);
        #1 Data_valid = 1'b0;
        check("count_after_write", Fifo_count, 1);
        @(posedge clk);
        #1 check("tx_before_start", TX_out, 1);
        check("count_after_pop", Fifo_count, 0);
        @(posedge clk);
        #1 check("tx_start_latency", TX_out, 0);
      end
      measure_busy(len);
    join
    check("busy_len_basic", len, 40);
    wait_idle();
    check("count_idle_basic", Fifo_count, 0);

    // Parity variants and two stop bits with divisor 0.
    single(make_frame(8'hA5, 2, 1, 0, 0), 2, 22, "busy_len_par_even");
    single(make_frame(8'hA5, 2, 1, 1, 0), 2, 22, "busy_len_par_odd");
    single(make_frame(8'h01, 2, 1, 0, 0), 2, 22, "busy_len_par_01");
    single(make_frame(8'hFF, 0, 0, 0, 1), 0, 11, "busy_len_stop2_div0");

    // FIFO fill with valid held six cycles; five contiguous frames follow.
    @(negedge clk);
    Baud_div = 16'd3; Par_en = 1'b0; Stop2 = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i > 0) @(negedge clk);
          P_data = 8'(8'h11 + i);
          Data_valid = 1'b1;
          check($sformatf("ready_fill_%0d", i), Data_ready, (i < 5) ? 1 : 0);
          if (i < 5) exp_q.push_back(make_frame(8'(8'h11 + i), 3, 0, 0, 0));
          @(posedge clk);
        end
        @(negedge clk);
        Data_valid = 1'b0;
        check("count_full", Fifo_count, 4);
        check("ready_when_full", Data_ready, 0);
      end
      measure_busy(len);
    join
    check("busy_len_back_to_back", len, 150);
    wait_idle();

    // Config changed mid-frame only affects the queued word.
    @(negedge clk);
    Baud_div = 16'd4; Par_en = 1'b0; Par_type = 1'b0; Stop2 = 1'b0;
    fork
      begin
        send(make_frame(8'h3C, 4, 0, 0, 0));
        send(make_frame(8'h5A, 8, 1, 0, 0));
        repeat (12) @(negedge clk);
        Baud_div = 16'd8;
        Par_en = 1'b1;
      end
      measure_busy(len);
    join
    check("busy_len_cfg_change", len, 40 + 88);
    wait_idle();

    // Randomized batches with random configuration per batch.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      div = int'($urandom_range(0, 5));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      Baud_div = DIVW'(div); Par_en = pe; Par_type = pt; Stop2 = s2;
      for (int k = 0; k < 6; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(make_frame(8'($urandom), div, pe, pt, s2));
      end
      wait_idle();
    end

    // Reset during data bit 3 with two words still queued.
    @(negedge clk);
    Baud_div = 16'd4; Par_en = 1'b0; Stop2 = 1'b0;
    fork
      begin
        send(make_frame(8'hC3, 4, 0, 0, 0));
        send(make_frame(8'h5A, 4, 0, 0, 0));
        send(make_frame(8'h96, 4, 0, 0, 0));
      end
      begin
        w = 0;
        @(negedge clk);
        while (TX_out && w < 200) begin
          @(negedge clk);
          w++;
        end
        repeat (18) @(negedge clk);
      end
    join
    check("count_before_reset", Fifo_count, 2);
    #2 rst = 1'b0;
    #1;
    check("midreset_tx", TX_out, 1);
    check("midreset_busy", Busy, 0);
    check("midreset_count", Fifo_count, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (TX_out !== 1'b1 || Busy !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);
    single(make_frame(8'h81, 1, 1, 1, 0), 1, 11, "busy_len_after_reset");

    check("leftover_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with a built-in baud divider and an input FIFO.
- Accepts parallel words on a valid/ready handshake and buffers them.
- Serialises each word as start, data LSB-first, optional parity and 1 or 2 stop bits, frames back-to-back.
- Sits on the TX side of the UART top, replacing the fixed-width, unbuffered, externally clocked transmitter.

Parameters:
DATA_WIDTH  8   data bits per frame (5..9)
FIFO_DEPTH  4   words buffered (power of two, >=2)
DIV_WIDTH   16  width of the baud divisor input

Ports:
clk         in   1                     single clock for the whole block
rst         in   1                     asynchronous, active-low reset
P_data      in   DATA_WIDTH            word to transmit
Data_valid  in   1                     P_data is valid this cycle
Data_ready  out  1                     FIFO can accept; =1 when not full
Par_en      in   1                     1 = append parity bit
Par_type    in   1                     0 = even, 1 = odd
Stop2       in   1                     1 = two stop bits
Baud_div    in   DIV_WIDTH             clocks per bit; 0 is treated as 1
TX_out      out  1                     serial line, idle high
Busy        out  1                     frame in progress
Fifo_count  out  clog2(FIFO_DEPTH+1)   words currently buffered

Behaviour:
Clock and reset:
- All state is on clk rising edge.
- rst low, asynchronously: TX_out=1, Busy=0, Fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- Data_ready=1 during reset, but writes are ignored while rst is low.

FIFO:
- Write occurs when Data_valid && Data_ready on a clock edge.
- Data_ready = (Fifo_count != FIFO_DEPTH), combinational from the count.
- Pop occurs on an FSM frame-start decision (see FSM).
- Simultaneous write and pop leaves the count unchanged; data order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- Valid while full is ignored and the word is dropped; the sender must hold it.

Config sampling:
- Par_en, Par_type, Stop2 and Baud_div (0 mapped to 1) are latched with the popped word.
- Changes mid-frame have no effect on the frame in progress.

Bit timing:
- Each serial bit lasts exactly N = latched divisor clocks, counted by the baud counter.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_out=1, Busy=0. If Fifo_count!=0, pop the word and go to START next cycle.
- START: TX_out=0 for N clocks, then DATA.
- DATA: TX_out=shift[0] for N clocks per bit, LSB first, DATA_WIDTH bits. Then PARITY if Par_en, else STOP.
- PARITY: TX_out = ^data for even, ~^data for odd, for N clocks, then STOP.
- STOP: TX_out=1 for N clocks (2N if Stop2).
  - On the final stop clock, if the FIFO is non-empty: pop and go to START, so the next frame follows with zero idle cycles.
  - Otherwise go to IDLE.
- Busy=1 in every state except IDLE.

Frame length:
- (1 + DATA_WIDTH + Par_en + 1 + Stop2) * N clocks.
- The first start-bit clock is the cycle after the pop.

Latency:
- Write into an empty FIFO while IDLE: Fifo_count=1 the next cycle, pop the cycle after, TX_out falls the cycle after that.
- Total is 3 edges from the accepted write to the start bit.

TX_out is registered (no combinational glitches).

Reset mid-frame:
- Line returns high immediately.
- FIFO contents are discarded.
- No partial-frame resumption.

Test Plan:
- Basic frame: DATA_WIDTH=8, Baud_div=4, Par_en=0, Stop2=0, write 0xA5.
  - TX_out = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clocks.
  - Busy high for exactly 40 clocks; Fifo_count returns to 0.
- Parity: 0xA5 (four ones), Baud_div=2, Par_en=1.
  - Par_type=0 gives parity bit 0; Par_type=1 gives parity bit 1.
  - Frame is 22 clocks. Repeat with 0x01: even gives 1.
- Stop2 and divisor 0: Baud_div=0, Stop2=1, write 0xFF.
  - Every bit lasts 1 clock; 11-clock frame; TX_out high for the last 2 clocks.
- FIFO full and back-to-back: FIFO_DEPTH=4, Baud_div=3.
  - Hold Data_valid for 6 consecutive cycles with 0x11..0x16, first word popped.
  - Data_ready drops once count=4; 0x11..0x15 are accepted and 0x16 is rejected.
  - Five frames of 30 clocks each, contiguous with no idle-high gap between them.
  - Bytes emitted in order 0x11..0x15.
- Config change mid-frame: start 0x3C with Baud_div=4, change to 8 and set Par_en=1 during DATA.
  - Current frame keeps 4-clock bits and has no parity.
  - The next queued frame uses 8-clock bits with parity.
- Reset mid-frame: assert rst low during DATA bit 3 with 2 words queued.
  - TX_out=1, Busy=0, Fifo_count=0 immediately, before the next clk edge.
  - After release, the line stays idle until a new write.
